btb_update_unit: RTL and testbench

Branch-resolution-side writer for the fetch-stage BTB and global 2-bit predictor.
- Takes resolved branch/jump outcomes from the resolve stage.
- Detects mispredictions and issues a one-cycle flush/redirect.
- Updates the global saturating counter.
- Queues BTB tag/target writes and drains them over a valid/ready write port into the BTB storage read by fetch.

---
 rtl/btb_update_unit.sv | 160 ++++++++++++++++
 tb/tb_btb_update_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/btb_update_unit.sv
// Resolve-side BTB writer: mispredict flush/redirect, global 2-bit counter,
// and a small coalescing write FIFO. Optional stats outputs under BTB_STATS_EN.
module btb_update_unit #(
    parameter int IDX_W      = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               res_valid,
    output logic               res_ready,
    input  logic               res_is_branch,
    input  logic               res_taken,
    input  logic [15:0]        res_PC,
    input  logic [15:0]        res_target,
    input  logic [15:0]        res_pred_PC,
    output logic               flush,
    output logic [15:0]        redirect_PC,
    output logic               pred_taken,
    output logic [1:0]         ctr_state,
`ifdef BTB_STATS_EN
    output logic [15:0]        stat_branches,
    output logic [15:0]        stat_mispredicts,
`endif
    output logic               btb_wr_valid,
    input  logic               btb_wr_ready,
    output logic [IDX_W-1:0]   btb_wr_index,
    output logic [15-IDX_W:0]  btb_wr_tag,
    output logic [15:0]        btb_wr_target
);

    localparam int TAG_W = 16 - IDX_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [TAG_W-1:0] tag;
        logic [15:0]      tgt;
    } entry_t;

    entry_t           mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W:0]   cnt_q;
    logic             flush_q;
    logic [15:0]      redirect_q;
    logic [1:0]       ctr_q;

    logic        fifo_full;
    logic        fifo_empty;
    logic        accept;
    logic [15:0] actual_next;
    logic        mispredict;
    logic        push_req;
    logic        pop;
    logic        tail_popped;
    logic        coalesce;
    logic        do_push;
    entry_t      new_ent;

    // Resolve-side decode: correct next PC, mispredict, push/pop/coalesce
    always_comb begin
        fifo_full   = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));
        fifo_empty  = (cnt_q == '0);
        accept      = res_valid && !fifo_full;
        actual_next = res_taken ? res_target : res_PC + 16'd1;
        mispredict  = (res_pred_PC != actual_next);
        push_req    = accept && res_taken && mispredict
                      && (res_target != 16'hFFFF);
        pop         = !fifo_empty && btb_wr_ready;
        tail_ptr    = wr_ptr_q - PTR_W'(1);
        tail_popped = pop && (cnt_q == (PTR_W+1)'(1));
        new_ent.idx = res_PC[IDX_W-1:0];
        new_ent.tag = res_PC[15:IDX_W];
        new_ent.tgt = res_target;
        coalesce    = push_req && !fifo_empty && !tail_popped
                      && (mem_q[tail_ptr].idx == new_ent.idx);
        do_push     = push_req && !coalesce;
    end

    assign res_ready     = !fifo_full;
    assign flush         = flush_q;
    assign redirect_PC   = redirect_q;
    assign ctr_state     = ctr_q;
    assign pred_taken    = ctr_q[1];
    assign btb_wr_valid  = !fifo_empty;
    assign btb_wr_index  = mem_q[rd_ptr_q].idx;
    assign btb_wr_tag    = mem_q[rd_ptr_q].tag;
    assign btb_wr_target = mem_q[rd_ptr_q].tgt;

    // One-cycle flush pulse; redirect target held between flushes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_q    <= 1'b0;
            redirect_q <= '0;
        end else begin
            flush_q <= accept && mispredict;
            if (accept && mispredict)
                redirect_q <= actual_next;
        end
    end

    // Global saturating direction counter, branches only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctr_q <= 2'b00;
        end else if (accept && res_is_branch) begin
            if (res_taken && ctr_q != 2'b11)
                ctr_q <= ctr_q + 2'b01;
            else if (!res_taken && ctr_q != 2'b00)
                ctr_q <= ctr_q - 2'b01;
        end
    end

    // Write FIFO: push, in-place tail coalesce, pop toward BTB
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= new_ent;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (coalesce)
                mem_q[tail_ptr] <= new_ent;
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !pop)
                cnt_q <= cnt_q + (PTR_W+1)'(1);
            else if (!do_push && pop)
                cnt_q <= cnt_q - (PTR_W+1)'(1);
        end
    end

`ifdef BTB_STATS_EN
    logic [15:0] stat_br_q;
    logic [15:0] stat_mp_q;

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;

    // Saturating event counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            if (accept && res_is_branch && stat_br_q != 16'hFFFF)
                stat_br_q <= stat_br_q + 16'd1;
            if (accept && mispredict && stat_mp_q != 16'hFFFF)
                stat_mp_q <= stat_mp_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_btb_update_unit.sv
// Directed bench for btb_update_unit: flush/redirect, counter,
// FIFO ordering/backpressure, coalescing, empty-marker and reset.
module tb_btb_update_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        res_valid;
    logic        res_ready;
    logic        res_is_branch;
    logic        res_taken;
    logic [15:0] res_PC;
    logic [15:0] res_target;
    logic [15:0] res_pred_PC;
    logic        flush;
    logic [15:0] redirect_PC;
    logic        pred_taken;
    logic [1:0]  ctr_state;
    logic        btb_wr_valid;
    logic        btb_wr_ready;
    logic [7:0]  btb_wr_index;
    logic [7:0]  btb_wr_tag;
    logic [15:0] btb_wr_target;
`ifdef BTB_STATS_EN
    logic [15:0] stat_branches;
    logic [15:0] stat_mispredicts;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    btb_update_unit #(.IDX_W(8), .FIFO_DEPTH(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_is_branch (res_is_branch),
        .res_taken     (res_taken),
        .res_PC        (res_PC),
        .res_target    (res_target),
        .res_pred_PC   (res_pred_PC),
        .flush         (flush),
        .redirect_PC   (redirect_PC),
        .pred_taken    (pred_taken),
        .ctr_state     (ctr_state),
`ifdef BTB_STATS_EN
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts),
`endif
        .btb_wr_valid  (btb_wr_valid),
        .btb_wr_ready  (btb_wr_ready),
        .btb_wr_index  (btb_wr_index),
        .btb_wr_tag    (btb_wr_tag),
        .btb_wr_target (btb_wr_target)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ev(input logic br, input logic tk, input logic [15:0] pc,
                      input logic [15:0] tgt, input logic [15:0] pred);
        res_valid     = 1'b1;
        res_is_branch = br;
        res_taken     = tk;
        res_PC        = pc;
        res_target    = tgt;
        res_pred_PC   = pred;
    endtask

    task automatic do_reset;
        res_valid = 1'b0;
        reset     = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        res_valid = 1'b0;
        res_is_branch = 1'b0;
        res_taken = 1'b0;
        res_PC = '0;
        res_target = '0;
        res_pred_PC = '0;
        btb_wr_ready = 1'b0;
        do_reset();

        chk("rst_flush", flush, 0);
        chk("rst_redir", redirect_PC, 0);
        chk("rst_ctr", ctr_state, 0);
        chk("rst_pred", pred_taken, 0);
        chk("rst_wrv", btb_wr_valid, 0);
        chk("rst_idx", btb_wr_index, 0);
        chk("rst_tgt", btb_wr_target, 0);
        chk("rst_rdy", res_ready, 1);

        // taken branch mispredict with BTB write
        ev(1, 1, 16'h0120, 16'h0200, 16'h0121);
        tick();
        res_valid = 1'b0;
        chk("t2_flush", flush, 1);
        chk("t2_redir", redirect_PC, 16'h0200);
        chk("t2_wrv", btb_wr_valid, 1);
        chk("t2_idx", btb_wr_index, 8'h20);
        chk("t2_tag", btb_wr_tag, 8'h01);
        chk("t2_tgt", btb_wr_target, 16'h0200);
        chk("t2_ctr", ctr_state, 1);
        tick();
        chk("t2_unflush", flush, 0);
        chk("t2_hold_redir", redirect_PC, 16'h0200);
        chk("t2_stall_tgt", btb_wr_target, 16'h0200);
        btb_wr_ready = 1'b1;
        tick();
        chk("t2_drained", btb_wr_valid, 0);

        // correctly predicted: counter walk 1,2,3,3,2,1
        do_reset();
        ev(1, 1, 16'h0300, 16'h0400, 16'h0400);
        tick(); chk("t3_c1", ctr_state, 1);
        tick(); chk("t3_c2", ctr_state, 2);
        chk("t3_pt", pred_taken, 1);
        tick(); chk("t3_c3", ctr_state, 3);
        tick(); chk("t3_c3s", ctr_state, 3);
        ev(1, 0, 16'h0300, 16'h0400, 16'h0301);
        tick(); chk("t3_c2d", ctr_state, 2);
        tick(); chk("t3_c1d", ctr_state, 1);
        chk("t3_pnt", pred_taken, 0);
        chk("t3_flush", flush, 0);
        chk("t3_wrv", btb_wr_valid, 0);
        res_valid = 1'b0;

        // backpressure: two queued, third stalls until first pop
        btb_wr_ready = 1'b0;
        ev(1, 1, 16'h0510, 16'h1000, 16'h0511);
        tick();
        chk("t4_fa", flush, 1);
        ev(1, 1, 16'h0511, 16'h1100, 16'h0512);
        tick();
        chk("t4_fb", flush, 1);
        chk("t4_rb", redirect_PC, 16'h1100);
        chk("t4_full", res_ready, 0);
        chk("t4_head0", btb_wr_index, 8'h10);
        ev(1, 1, 16'h0512, 16'h1200, 16'h0513);
        tick();
        chk("t4_noacc_fl", flush, 0);
        chk("t4_stable", btb_wr_index, 8'h10);
        chk("t4_ctr", ctr_state, 3);
        btb_wr_ready = 1'b1;
        tick();
        chk("t4_head1", btb_wr_index, 8'h11);
        chk("t4_head1t", btb_wr_target, 16'h1100);
        chk("t4_rdy", res_ready, 1);
        chk("t4_noacc2", flush, 0);
        tick();
        res_valid = 1'b0;
        chk("t4_fc", flush, 1);
        chk("t4_head2", btb_wr_index, 8'h12);
        chk("t4_head2t", btb_wr_target, 16'h1200);
        tick();
        chk("t4_empty", btb_wr_valid, 0);

        // same index twice coalesces into one entry
        btb_wr_ready = 1'b0;
        ev(1, 1, 16'h0730, 16'h0800, 16'h0731);
        tick();
        ev(1, 1, 16'h0830, 16'h0900, 16'h0831);
        tick();
        res_valid = 1'b0;
        chk("t5_rdy", res_ready, 1);
        chk("t5_idx", btb_wr_index, 8'h30);
        chk("t5_tag", btb_wr_tag, 8'h08);
        chk("t5_tgt", btb_wr_target, 16'h0900);
        btb_wr_ready = 1'b1;
        tick();
        chk("t5_one", btb_wr_valid, 0);

        // jump to the empty marker: flush but no write
        ev(0, 1, 16'h0040, 16'hFFFF, 16'h0041);
        tick();
        res_valid = 1'b0;
        chk("t6_flush", flush, 1);
        chk("t6_redir", redirect_PC, 16'hFFFF);
        chk("t6_wrv", btb_wr_valid, 0);
        chk("t6_ctr", ctr_state, 3);

        // PC+1 wrap at 16'hFFFF
        ev(1, 0, 16'hFFFF, 16'h1234, 16'h0000);
        tick();
        chk("t7_nofl", flush, 0);
        chk("t7_ctr", ctr_state, 2);
        ev(1, 0, 16'hFFFF, 16'h1234, 16'h1234);
        tick();
        res_valid = 1'b0;
        chk("t7_fl", flush, 1);
        chk("t7_redir", redirect_PC, 16'h0000);
        chk("t7_wrv", btb_wr_valid, 0);

        // async reset with a full queue and flush high
        btb_wr_ready = 1'b0;
        ev(1, 1, 16'h0A01, 16'h0B00, 16'h0A02);
        tick();
        ev(1, 1, 16'h0A02, 16'h0C00, 16'h0A03);
        tick();
        res_valid = 1'b0;
        chk("t8_pre_fl", flush, 1);
        chk("t8_pre_rdy", res_ready, 0);
        reset = 1'b1;
        #1;
        chk("t8_async_fl", flush, 0);
        chk("t8_async_wrv", btb_wr_valid, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("t8_fl", flush, 0);
        chk("t8_wrv", btb_wr_valid, 0);
        chk("t8_ctr", ctr_state, 0);
        chk("t8_rdy", res_ready, 1);
        chk("t8_idx", btb_wr_index, 0);
        chk("t8_redir", redirect_PC, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
